// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI definitions for the SRAM slave: request/response bundles, burst and response codes, FSM states.
package axi_sram_slave_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_BURST} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              bready;
  } axi_req_t;

  typedef struct packed {
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              awready;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
  } axi_resp_t;

  // Wrapping bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED/INCR bursts; WRAP handled only with AXI_SRAM_WRAP_BURST_EN, else as INCR.
// Purely combinational, no state.
module axi_burst_addr_gen
  import axi_sram_slave_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  input  logic [7:0]        len_i,
  output logic [ADDR_W-1:0] next_o
);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] sum;

  assign incr = ADDR_W'(1) << size_i;
  assign sum  = addr_i + incr;

`ifdef AXI_SRAM_WRAP_BURST_EN
  logic [ADDR_W-1:0] wrap_mask;
  assign wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);

  always_comb begin
    next_o = sum;
    if (burst_i == BURST_FIXED) begin
      next_o = addr_i;
    end else if ((burst_i == BURST_WRAP) && wrap_len_ok(len_i)) begin
      next_o = (addr_i & ~wrap_mask) | (sum & wrap_mask);
    end
  end
`else
  logic unused_len;
  assign unused_len = ^len_i;

  always_comb begin
    next_o = sum;
    if (burst_i == BURST_FIXED) begin
      next_o = addr_i;
    end
  end
`endif

endmodule

// File: rtl/axi_sram_slave.sv
// AXI SRAM slave: independent read/write FSMs, read latency 1, read-first array; rdata held while stalled.
// WRAP bursts wrap only when AXI_SRAM_WRAP_BURST_EN is defined, otherwise they behave as INCR.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int    BUS_WIDTH = 4,
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  axi_req_t             axi_req,
  output axi_resp_t            axi_resp,
  input  logic [BUS_WIDTH-1:0] arid,
  input  logic [BUS_WIDTH-1:0] awid,
  input  logic [BUS_WIDTH-1:0] wid,
  output logic [BUS_WIDTH-1:0] rid,
  output logic [BUS_WIDTH-1:0] bid
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  // ---------------- read channel ----------------
  rd_state_e          rstate_q, rstate_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d, rnext;
  logic [7:0]         rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]         rsize_q, rsize_d;
  logic [1:0]         rburst_q, rburst_d;
  logic [BUS_WIDTH-1:0] rid_q, rid_d;
  logic [DATA_W-1:0]  rdata_q;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_idx;

  axi_burst_addr_gen u_rd_addr (
    .addr_i  (raddr_q),
    .size_i  (rsize_q),
    .burst_i (rburst_q),
    .len_i   (rlen_q),
    .next_o  (rnext)
  );

  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rbeat_d  = rbeat_q;
    rid_d    = rid_q;
    rd_en    = 1'b0;
    rd_idx   = raddr_q[IDX_W+1:2];
    case (rstate_q)
      R_IDLE: begin
        if (axi_req.arvalid) begin
          rstate_d = R_BURST;
          raddr_d  = axi_req.araddr;
          rlen_d   = axi_req.arlen;
          rsize_d  = axi_req.arsize;
          rburst_d = axi_req.arburst;
          rid_d    = arid;
          rbeat_d  = '0;
          rd_en    = 1'b1;
          rd_idx   = axi_req.araddr[IDX_W+1:2];
        end
      end
      R_BURST: begin
        // Data register only moves on a handshake, so a stalled beat stays stable.
        if (axi_req.rready) begin
          if (rbeat_q == rlen_q) begin
            rstate_d = R_IDLE;
          end else begin
            rbeat_d = rbeat_q + 8'd1;
            raddr_d = rnext;
            rd_en   = 1'b1;
            rd_idx  = rnext[IDX_W+1:2];
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rbeat_q  <= '0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rbeat_q  <= rbeat_d;
      rid_q    <= rid_d;
      if (rd_en) begin
        rdata_q <= mem_q[rd_idx];
      end
    end
  end

  // ---------------- write channel ----------------
  wr_state_e          wstate_q, wstate_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d, wnext;
  logic [7:0]         wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]         wsize_q, wsize_d;
  logic [1:0]         wburst_q, wburst_d;
  logic [BUS_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               werr_q, werr_d;
  logic               mem_we;

  axi_burst_addr_gen u_wr_addr (
    .addr_i  (waddr_q),
    .size_i  (wsize_q),
    .burst_i (wburst_q),
    .len_i   (wlen_q),
    .next_o  (wnext)
  );

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wbeat_d  = wbeat_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    werr_d   = werr_q;
    mem_we   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (axi_req.awvalid) begin
          wstate_d = W_DATA;
          waddr_d  = axi_req.awaddr;
          wlen_d   = axi_req.awlen;
          wsize_d  = axi_req.awsize;
          wburst_d = axi_req.awburst;
          bid_d    = awid;
          wbeat_d  = '0;
          werr_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (axi_req.wvalid) begin
          mem_we = 1'b1;
          if (wbeat_q == wlen_q) begin
            wstate_d = W_RESP;
            bresp_d  = (werr_q || !axi_req.wlast) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            // An early wlast poisons the response but the burst still runs to awlen.
            wbeat_d = wbeat_q + 8'd1;
            waddr_d = wnext;
            werr_d  = werr_q | axi_req.wlast;
          end
        end
      end
      W_RESP: begin
        if (axi_req.bready) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wbeat_q  <= '0;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
      werr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wbeat_q  <= wbeat_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      werr_q   <= werr_d;
    end
  end

  // Array is never cleared; a read on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_req.wstrb[b]) begin
          mem_q[waddr_q[IDX_W+1:2]][8*b +: 8] <= axi_req.wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    axi_resp = '0;
    if (!rst) begin
      axi_resp.arready = (rstate_q == R_IDLE);
      axi_resp.rvalid  = (rstate_q == R_BURST);
      axi_resp.rlast   = (rstate_q == R_BURST) && (rbeat_q == rlen_q);
      axi_resp.rdata   = rdata_q;
      axi_resp.rresp   = RESP_OKAY;
      axi_resp.awready = (wstate_q == W_IDLE);
      axi_resp.wready  = (wstate_q == W_DATA);
      axi_resp.bvalid  = (wstate_q == W_RESP);
      axi_resp.bresp   = bresp_q;
    end
  end

  assign rid = rst ? '0 : rid_q;
  assign bid = rst ? '0 : bid_q;

  logic unused_wid;
  assign unused_wid = ^wid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with queued expected R/B responses checked by a negedge monitor.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  logic      clk = 1'b0;
  logic      rst;
  axi_req_t  req;
  axi_resp_t resp;
  logic [3:0] arid, awid, wid, rid, bid;

  always #5 clk = ~clk;

  axi_sram_slave #(.BUS_WIDTH(4), .MEM_WORDS(1024), .INIT_FILE("")) dut (
    .clk      (clk),
    .rst      (rst),
    .axi_req  (req),
    .axi_resp (resp),
    .arid     (arid),
    .awid     (awid),
    .wid      (wid),
    .rid      (rid),
    .bid      (bid)
  );

  int tests = 0;
  int fails = 0;
  rexp_t rq[$];
  bexp_t bq[$];
  rexp_t re;
  bexp_t be;
  logic [31:0] vec [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted R or B beat is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp.rvalid && req.rready) begin
        if (rq.size() == 0) begin
          chk("r_extra_beat", 32'(resp.rvalid), 32'd0);
        end else begin
          re = rq.pop_front();
          chk("rdata", resp.rdata, re.data);
          chk("rlast", 32'(resp.rlast), 32'(re.last));
          chk("rid", 32'(rid), 32'(re.id));
          chk("rresp", 32'(resp.rresp), 32'(RESP_OKAY));
        end
      end
      if (resp.bvalid && req.bready) begin
        if (bq.size() == 0) begin
          chk("b_extra_resp", 32'(resp.bvalid), 32'd0);
        end else begin
          be = bq.pop_front();
          chk("bresp", 32'(resp.bresp), 32'(be.resp));
          chk("bid", 32'(bid), 32'(be.id));
        end
      end
    end
  end

  function automatic logic rdy(input int ch);
    case (ch)
      0:       return resp.arready;
      1:       return resp.awready;
      default: return resp.wready;
    endcase
  endfunction

  task automatic handshake(input int ch, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(ch) && n < 64);
    chk(name, 32'(rdy(ch)), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_r();
    int n = 0;
    while (rq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("r_drain", 32'(rq.size()), 32'd0);
  endtask

  task automatic drain_b();
    int n = 0;
    while (bq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_drain", 32'(bq.size()), 32'd0);
  endtask

  task automatic setv(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    vec[0] = a;
    vec[1] = b;
    vec[2] = c;
    vec[3] = d;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id, input logic [3:0] strb,
                             input int last_beat, input logic [1:0] exp_resp, input int bdelay);
    bq.push_back('{resp: exp_resp, id: id});
    if (bdelay > 0) req.bready = 1'b0;
    @(posedge clk);
    #1;
    req.awaddr  = addr;
    req.awlen   = len;
    req.awsize  = size;
    req.awburst = burst;
    awid        = id;
    req.awvalid = 1'b1;
    handshake(1, "aw_ready");
    req.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      req.wdata  = vec[i];
      req.wstrb  = strb;
      req.wlast  = (i == last_beat);
      wid        = id;
      req.wvalid = 1'b1;
      handshake(2, "w_ready");
    end
    req.wvalid = 1'b0;
    req.wlast  = 1'b0;
    if (bdelay > 0) begin
      for (int i = 0; i < bdelay; i++) begin
        @(negedge clk);
        chk("bvalid_hold", 32'(resp.bvalid), 32'd1);
        chk("bresp_hold", 32'(resp.bresp), 32'(exp_resp));
      end
      @(posedge clk);
      #1;
      req.bready = 1'b1;
    end
    drain_b();
  endtask

  task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{data: vec[i], last: (i == int'(len)), id: id});
    end
    @(posedge clk);
    #1;
    req.araddr  = addr;
    req.arlen   = len;
    req.arsize  = size;
    req.arburst = burst;
    arid        = id;
    req.arvalid = 1'b1;
    handshake(0, "ar_ready");
    req.arvalid = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input bit lat_chk);
    issue_ar(addr, len, size, burst, id);
    if (lat_chk) begin
      @(negedge clk);
      chk("ar_to_rvalid_1cyc", 32'(resp.rvalid), 32'd1);
    end
    drain_r();
  endtask

  initial begin : wdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    req.rready = 1'b1;
    req.bready = 1'b1;
    arid = '0;
    awid = '0;
    wid  = '0;

    @(negedge clk);
    chk("rst_arready", 32'(resp.arready), 32'd0);
    chk("rst_awready", 32'(resp.awready), 32'd0);
    chk("rst_wready",  32'(resp.wready),  32'd0);
    chk("rst_rvalid",  32'(resp.rvalid),  32'd0);
    chk("rst_rlast",   32'(resp.rlast),   32'd0);
    chk("rst_bvalid",  32'(resp.bvalid),  32'd0);
    chk("rst_rdata",   resp.rdata,        32'd0);
    chk("rst_rid",     32'(rid),          32'd0);
    chk("rst_bid",     32'(bid),          32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_arready", 32'(resp.arready), 32'd1);
    chk("idle_awready", 32'(resp.awready), 32'd1);

    // Single word write and read back
    setv(32'h11223344, 0, 0, 0);
    write_burst(32'h100, 8'd0, 3'd2, BURST_INCR, 4'h3, 4'hF, 0, RESP_OKAY, 0);
    read_burst(32'h100, 8'd0, 3'd2, BURST_INCR, 4'h5, 1'b1);

    // Partial write keeps the upper half
    setv(32'hAAAABBBB, 0, 0, 0);
    write_burst(32'h100, 8'd0, 3'd2, BURST_INCR, 4'h4, 4'h3, 0, RESP_OKAY, 0);
    setv(32'h1122BBBB, 0, 0, 0);
    read_burst(32'h100, 8'd0, 3'd2, BURST_INCR, 4'h6, 1'b0);

    // Four-beat INCR burst
    setv(0, 1, 2, 3);
    write_burst(32'h200, 8'd3, 3'd2, BURST_INCR, 4'h1, 4'hF, 3, RESP_OKAY, 0);
    read_burst(32'h200, 8'd3, 3'd2, BURST_INCR, 4'h9, 1'b0);
    setv(32'hA10, 32'hA14, 0, 0);
    write_burst(32'h210, 8'd1, 3'd2, BURST_INCR, 4'h2, 4'hF, 1, RESP_OKAY, 0);

    // WRAP read starting mid-block
`ifdef AXI_SRAM_WRAP_BURST_EN
    setv(2, 3, 0, 1);
`else
    setv(2, 3, 32'hA10, 32'hA14);
`endif
    read_burst(32'h208, 8'd3, 3'd2, BURST_WRAP, 4'hA, 1'b0);

    // Halfword beats step by 2 bytes
    setv(0, 0, 1, 0);
    read_burst(32'h200, 8'd2, 3'd1, BURST_INCR, 4'hB, 1'b0);

    // FIXED bursts stay on one word
    setv(5, 6, 7, 0);
    write_burst(32'h300, 8'd2, 3'd2, BURST_FIXED, 4'h7, 4'hF, 2, RESP_OKAY, 0);
    setv(7, 7, 0, 0);
    read_burst(32'h300, 8'd1, 3'd2, BURST_FIXED, 4'hC, 1'b0);

    // Address above the array aliases onto word 0x40
    setv(32'h1122BBBB, 0, 0, 0);
    read_burst(32'h1100, 8'd0, 3'd2, BURST_INCR, 4'hD, 1'b0);

    // Early wlast gives SLVERR, held while bready is low
    setv(32'h40, 32'h41, 32'h42, 32'h43);
    write_burst(32'h400, 8'd3, 3'd2, BURST_INCR, 4'hE, 4'hF, 1, RESP_SLVERR, 5);

    // Stall on beat 1 while the same word is overwritten, then reset mid-burst
    setv(0, 1, 2, 3);
    issue_ar(32'h200, 8'd3, 3'd2, BURST_INCR, 4'h8);
    @(posedge clk);
    #1;
    req.rready = 1'b0;
    setv(32'hDEAD0001, 0, 0, 0);
    fork
      write_burst(32'h204, 8'd0, 3'd2, BURST_INCR, 4'h6, 4'hF, 0, RESP_OKAY, 0);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("stall_rvalid", 32'(resp.rvalid), 32'd1);
          chk("stall_rdata", resp.rdata, 32'd1);
          chk("stall_rlast", 32'(resp.rlast), 32'd0);
          chk("stall_rid", 32'(rid), 32'h8);
        end
      end
    join
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rvalid", 32'(resp.rvalid), 32'd0);
    chk("midrst_arready", 32'(resp.arready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rq.delete();
    rst = 1'b0;
    req.rready = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", 32'(resp.rvalid), 32'd0);
    chk("post_rst_bvalid", 32'(resp.bvalid), 32'd0);
    chk("post_rst_arready", 32'(resp.arready), 32'd1);

    setv(0, 32'hDEAD0001, 0, 0);
    read_burst(32'h200, 8'd1, 3'd2, BURST_INCR, 4'h3, 1'b1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
